// File: rtl/obstacle_track_pkg.sv
// Shared types and constants for the obstacle track.
// The optional OBSTACLE_TRACK_BORDER_MASK_EN build uses BORDER_MASK on pattern load.
package obstacle_track_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CRASH = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int ROW_W = 8;
  localparam int SEQ_W = 16;

  // Generator always sets columns 0 and 7 of each row; these bits clear them.
  localparam logic [SEQ_W-1:0] BORDER_MASK = 16'h7E7E;

endpackage

// File: rtl/obstacle_track_pattern_buf.sv
// Single-entry pattern buffer: accepts one 16-bit pattern and hands out one column per consume.
// Build option OBSTACLE_TRACK_BORDER_MASK_EN strips border bits on load.
module track_pattern_buf
  import obstacle_track_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEQ_W-1:0] seq_in,
  input  logic             seq_valid,
  output logic             seq_ready,
  input  logic             consume,
  output logic             new_top,
  output logic             new_bot,
  output logic             empty
);

  logic [SEQ_W-1:0] pend;
  logic             pend_full;
  logic [2:0]       col_idx;
  logic [SEQ_W-1:0] load_val;
  logic [ROW_W-1:0] top_byte;
  logic [ROW_W-1:0] bot_byte;
  logic             load;

`ifdef OBSTACLE_TRACK_BORDER_MASK_EN
  assign load_val = seq_in & BORDER_MASK;
`else
  assign load_val = seq_in;
`endif

  assign seq_ready = ~pend_full;
  assign empty     = ~pend_full;
  assign load      = seq_valid & ~pend_full;
  assign top_byte  = pend[SEQ_W-1:ROW_W];
  assign bot_byte  = pend[ROW_W-1:0];
  assign new_top   = pend_full & top_byte[col_idx];
  assign new_bot   = pend_full & bot_byte[col_idx];

  // Loading and consuming are exclusive: load needs empty, consume needs full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      pend_full <= 1'b0;
      col_idx   <= 3'd0;
    end else if (load) begin
      pend      <= load_val;
      pend_full <= 1'b1;
      col_idx   <= 3'd0;
    end else if (consume && pend_full) begin
      col_idx <= col_idx + 3'd1;
      if (col_idx == 3'd7) pend_full <= 1'b0;
    end
  end

endmodule

// File: rtl/obstacle_track.sv
// Two-lane scrolling obstacle track with collision detection, lives, score and game FSM.
// Optional build macro OBSTACLE_TRACK_BORDER_MASK_EN (handled in the pattern buffer).
module obstacle_track
  import obstacle_track_pkg::*;
#(
  parameter int SCORE_W       = 14,
  parameter int LIVES         = 3,
  parameter int RECOVER_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               start,
  input  logic               car_lane,
  input  logic [SEQ_W-1:0]   seq_in,
  input  logic               seq_valid,
  output logic               seq_ready,
  output logic [ROW_W-1:0]   row_top,
  output logic [ROW_W-1:0]   row_bot,
  output logic               collision,
  output logic               game_over,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               underrun
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [3:0] crash_cnt;
  logic       hit;
  logic       consume;
  logic       new_top;
  logic       new_bot;
  logic       empty;

  // Collision uses the registered rows, so it lands one clk after the shift.
  assign hit       = (state == RUN) && (car_lane ? row_bot[0] : row_top[0]);
  assign consume   = (state == RUN) && tick && !hit;
  assign game_over = (state == OVER);

  track_pattern_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .seq_in    (seq_in),
    .seq_valid (seq_valid),
    .seq_ready (seq_ready),
    .consume   (consume),
    .new_top   (new_top),
    .new_bot   (new_bot),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_top   <= '0;
      row_bot   <= '0;
      collision <= 1'b0;
      lives     <= 3'd0;
      score     <= '0;
      underrun  <= 1'b0;
      crash_cnt <= 4'd0;
    end else begin
      collision <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= RUN;
            lives     <= LIVES[2:0];
            score     <= '0;
            row_top   <= '0;
            row_bot   <= '0;
            underrun  <= 1'b0;
            crash_cnt <= 4'd0;
          end
        end
        RUN: begin
          if (hit) begin
            collision <= 1'b1;
            lives     <= lives - 3'd1;
            row_top   <= '0;
            row_bot   <= '0;
            if (lives == 3'd1) begin
              state <= OVER;
            end else begin
              state     <= CRASH;
              crash_cnt <= RECOVER_TICKS[3:0];
            end
          end else if (tick) begin
            row_top <= {new_top, row_top[ROW_W-1:1]};
            row_bot <= {new_bot, row_bot[ROW_W-1:1]};
            if (empty) underrun <= 1'b1;
            if (score != SCORE_MAX) score <= score + SCORE_ONE;
          end
        end
        CRASH: begin
          if (tick) begin
            if (crash_cnt <= 4'd1) begin
              crash_cnt <= 4'd0;
              state     <= RUN;
            end else begin
              crash_cnt <= crash_cnt - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_track.sv
// Directed self-checking bench for obstacle_track (default parameters).
module tb_obstacle_track;

`ifdef OBSTACLE_TRACK_BORDER_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        car_lane = 1'b0;
  logic [15:0] seq_in = 16'h0000;
  logic        seq_valid = 1'b0;
  logic        seq_ready;
  logic [7:0]  row_top;
  logic [7:0]  row_bot;
  logic        collision;
  logic        game_over;
  logic [2:0]  lives;
  logic [13:0] score;
  logic        underrun;

  int tests_run = 0;
  int tests_failed = 0;
  int xfer_cnt = 0;
  int xfer_base = 0;
  bit feed_en = 1'b0;

  obstacle_track dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .start     (start),
    .car_lane  (car_lane),
    .seq_in    (seq_in),
    .seq_valid (seq_valid),
    .seq_ready (seq_ready),
    .row_top   (row_top),
    .row_bot   (row_bot),
    .collision (collision),
    .game_over (game_over),
    .lives     (lives),
    .score     (score),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (seq_valid && seq_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [15:0] feed_val();
    int d;
    d = xfer_cnt - xfer_base;
    return d[0] ? 16'h0000 : 16'hFF00;
  endfunction

  // One tick pulse spanning exactly one rising edge; returns on the following negedge.
  task automatic do_tick();
    @(negedge clk);
    if (feed_en) seq_in = feed_val();
    tick = 1'b1;
    @(negedge clk);
    if (feed_en) seq_in = feed_val();
    tick = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic load(input logic [15:0] v);
    @(negedge clk);
    seq_in = v;
    seq_valid = 1'b1;
    @(negedge clk);
    seq_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(seq_ready), 32'd1);
    check("rst_rows", {16'h0, row_top, row_bot}, 32'h0);
    check("rst_lives", 32'(lives), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_coll", 32'(collision), 32'd0);
    check("rst_under", 32'(underrun), 32'd0);
    rst_n = 1'b1;

    // Start with no patterns: underrun
    pulse_start();
    check("start_lives", 32'(lives), 32'd3);
    do_ticks(3);
    check("t1_score", 32'(score), 32'd3);
    check("t1_under", 32'(underrun), 32'd1);
    check("t1_rows", {16'h0, row_top, row_bot}, 32'h0);
    check("t1_ready", 32'(seq_ready), 32'd1);

    // Top col-0 obstacle scrolls through, car in bottom lane
    car_lane = 1'b1;
    load(16'h0100);
    check("t2_ready_lo", 32'(seq_ready), 32'd0);
    do_tick();
    check("t2_top_1", 32'(row_top), 32'h80);
    do_ticks(6);
    check("t2_ready_7", 32'(seq_ready), 32'd0);
    do_tick();
    check("t2_top_8", 32'(row_top), 32'h01);
    check("t2_bot_8", 32'(row_bot), 32'h00);
    check("t2_score", 32'(score), 32'd11);
    check("t2_ready_8", 32'(seq_ready), 32'd1);
    check("t2_nocoll", 32'(collision), 32'd0);

    // Switch into the obstacle lane: hit
    @(negedge clk);
    car_lane = 1'b0;
    @(negedge clk);
    check("t3_coll", 32'(collision), 32'd1);
    check("t3_lives", 32'(lives), 32'd2);
    check("t3_rows", {16'h0, row_top, row_bot}, 32'h0);
    @(negedge clk);
    check("t3_coll_pulse", 32'(collision), 32'd0);

    // CRASH: pattern loaded but not consumed for 4 ticks
    load(16'h0001);
    do_ticks(4);
    check("t3_crash_score", 32'(score), 32'd11);
    check("t3_crash_ready", 32'(seq_ready), 32'd0);
    check("t3_crash_rows", {16'h0, row_top, row_bot}, 32'h0);
    do_tick();
    check("t3_resume_bot", 32'(row_bot), 32'h80);
    check("t3_resume_score", 32'(score), 32'd12);
    do_ticks(7);
    check("t3_bot_8", 32'(row_bot), 32'h01);
    check("t3_score_8", 32'(score), 32'd19);
    check("t3_ready_8", 32'(seq_ready), 32'd1);

    // Second hit (bottom lane)
    car_lane = 1'b1;
    @(negedge clk);
    check("t4_coll2", 32'(collision), 32'd1);
    check("t4_lives2", 32'(lives), 32'd1);
    do_ticks(4);
    load(16'h0001);
    do_ticks(8);
    check("t4_bot_8", 32'(row_bot), 32'h01);
    check("t4_score", 32'(score), 32'd27);
    @(negedge clk);
    check("t4_coll3", 32'(collision), 32'd1);
    check("t4_lives0", 32'(lives), 32'd0);
    check("t4_over", 32'(game_over), 32'd1);
    do_ticks(3);
    check("t4_frozen_score", 32'(score), 32'd27);
    check("t4_frozen_rows", {16'h0, row_top, row_bot}, 32'h0);
    check("t4_still_over", 32'(game_over), 32'd1);
    pulse_start();
    check("t4_restart_lives", 32'(lives), 32'd3);
    check("t4_restart_score", 32'(score), 32'd0);
    check("t4_restart_over", 32'(game_over), 32'd0);
    check("t4_restart_under", 32'(underrun), 32'd0);

    // Back-to-back patterns with seq_valid held high
    car_lane = 1'b1;
    xfer_base = xfer_cnt;
    @(negedge clk);
    feed_en = 1'b1;
    seq_in = feed_val();
    seq_valid = 1'b1;
    do_ticks(8);
    check("t5_xfer_8", 32'(xfer_cnt - xfer_base), 32'd1);
    check("t5_top_8", 32'(row_top), 32'hFF);
    do_ticks(8);
    check("t5_xfer_16", 32'(xfer_cnt - xfer_base), 32'd2);
    check("t5_top_16", 32'(row_top), 32'h00);
    do_ticks(8);
    seq_valid = 1'b0;
    feed_en = 1'b0;
    check("t5_xfer_24", 32'(xfer_cnt - xfer_base), 32'd3);
    check("t5_top_24", 32'(row_top), 32'hFF);
    check("t5_bot_24", 32'(row_bot), 32'h00);
    check("t5_score", 32'(score), 32'd24);
    check("t5_under", 32'(underrun), 32'd0);
    do_ticks(8);
    check("t5_drain_top", 32'(row_top), 32'h00);
    check("t5_drain_under", 32'(underrun), 32'd1);
    check("t5_drain_xfer", 32'(xfer_cnt - xfer_base), 32'd3);

    // Border bits: pattern 8181 in the car's lane
    car_lane = 1'b0;
    load(16'h8181);
    do_tick();
    check("t6_top_1", 32'(row_top), MASK_EN ? 32'h00 : 32'h80);
    do_ticks(7);
    check("t6_top_8", 32'(row_top), MASK_EN ? 32'h00 : 32'h81);
    check("t6_bot_8", 32'(row_bot), MASK_EN ? 32'h00 : 32'h81);
    @(negedge clk);
    check("t6_coll", 32'(collision), MASK_EN ? 32'd0 : 32'd1);
    check("t6_lives", 32'(lives), MASK_EN ? 32'd3 : 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
